// File: rtl/fir_sample_source.sv
// fir_sample_source: host-side sample FIFO feeding the first FIR stage's
// ready-flag/data stream, one sample per EN cycle, with frame tracking.
// Optional build macro FIR_SRC_FLUSH_EN appends FLUSH_LEN zero samples after
// every frame and moves the FRAME_DONE pulse to the last of those zeros.
module fir_sample_source #(
  parameter int unsigned N         = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned FLUSH_LEN = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   WR_VALID,
  input  logic [N-1:0]           WR_DATA,
  input  logic                   WR_LAST,
  output logic                   WR_READY,
  output logic                   R_OUT,
  output logic [N-1:0]           D_OUT,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   FRAME_DONE,
  output logic                   BUSY
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
`ifdef FIR_SRC_FLUSH_EN
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam int unsigned CNT_W    = $clog2(FLUSH_LEN + 1);
`endif

  // Parameter legality: DEPTH a power of two >= 2, FLUSH_LEN >= 1.
  // Pointer wrap relies on the power-of-two depth; this block holds no logic.
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (FLUSH_LEN < 1)) begin : g_illegal_params
    end
  endgenerate

  // Each entry is {last, sample}
  logic [N:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [1:0]       state_q, state_d;
  logic             r_out_q, r_out_d;
  logic [N-1:0]     d_out_q, d_out_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
`ifdef FIR_SRC_FLUSH_EN
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
`endif

  logic             push;
  logic             pop;
  logic [N:0]       head;

  // Full is judged from the registered level only, so a same-cycle pop never
  // frees a slot for a push.
  assign WR_READY = (level_q != LVL_W'(DEPTH));
  assign push     = WR_VALID && WR_READY;
  // Head entry; D_OUT acts as the read register of the storage array.
  assign head     = mem_q[rd_ptr_q];

  // Pop whenever the stream advances and a sample is waiting (never while flushing)
  always_comb begin
    pop = EN && (level_q != '0);
`ifdef FIR_SRC_FLUSH_EN
    pop = pop && (state_q != ST_FLUSH);
`endif
  end

  // Next-state: pointers, occupancy, FSM and output stream
  always_comb begin
    wr_ptr_d     = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d     = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    level_d      = level_q;
    state_d      = state_q;
    r_out_d      = r_out_q;
    d_out_d      = d_out_q;
    frame_done_d = 1'b0;
`ifdef FIR_SRC_FLUSH_EN
    flush_cnt_d  = flush_cnt_q;
`endif

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (EN) begin
`ifdef FIR_SRC_FLUSH_EN
      if (state_q == ST_FLUSH) begin
        r_out_d = 1'b1;
        d_out_d = '0;
        if (flush_cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
          flush_cnt_d  = '0;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          flush_cnt_d  = flush_cnt_q + CNT_W'(1);
        end
      end else
`endif
      if (pop) begin
        r_out_d = 1'b1;
        d_out_d = head[N-1:0];
        if (head[N]) begin
`ifdef FIR_SRC_FLUSH_EN
          state_d      = ST_FLUSH;
`else
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
`endif
        end else begin
          state_d = ST_STREAM;
        end
      end else begin
        // Starved: drop the valid flag, keep the last sample on the bus
        r_out_d = 1'b0;
      end
    end

    busy_d = (level_d != '0) || (state_d != ST_IDLE);
  end

  // Sample storage: no reset so the array can map onto RAM; a reset only
  // clears the pointers, which discards whatever was queued.
  always_ff @(posedge CLK) begin
    if (RST && push) begin
      mem_q[wr_ptr_q] <= {WR_LAST, WR_DATA};
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= ST_IDLE;
      r_out_q      <= 1'b0;
      d_out_q      <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FIR_SRC_FLUSH_EN
      flush_cnt_q  <= '0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      state_q      <= state_d;
      r_out_q      <= r_out_d;
      d_out_q      <= d_out_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
`ifdef FIR_SRC_FLUSH_EN
      flush_cnt_q  <= flush_cnt_d;
`endif
    end
  end

  assign R_OUT      = r_out_q;
  assign D_OUT      = d_out_q;
  assign LEVEL      = level_q;
  assign FRAME_DONE = frame_done_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_fir_sample_source.sv
// Bench for fir_sample_source: stimulus pushes expected samples into a
// scoreboard queue; a monitor pops and compares on every emitted sample.
module tb_fir_sample_source;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN = 1'b0;
  logic        WR_VALID = 1'b0;
  logic [15:0] WR_DATA = '0;
  logic        WR_LAST = 1'b0;
  logic        WR_READY;
  logic        R_OUT;
  logic [15:0] D_OUT;
  logic [3:0]  LEVEL;
  logic        FRAME_DONE;
  logic        BUSY;

  fir_sample_source dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .WR_LAST(WR_LAST),
    .WR_READY(WR_READY), .R_OUT(R_OUT), .D_OUT(D_OUT),
    .LEVEL(LEVEL), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] d;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write one sample at a negedge; exp_acc is the hand-derived acceptance.
  task automatic wr(input logic [15:0] d, input logic l, input logic exp_acc);
    exp_t e;
    WR_VALID = 1'b1;
    WR_DATA  = d;
    WR_LAST  = l;
    chk("wr_ready", 32'(WR_READY), 32'(exp_acc));
    if (exp_acc) begin
`ifdef FIR_SRC_FLUSH_EN
      e.d = d; e.done = 1'b0;
      sb.push_back(e);
      if (l) begin
        for (int k = 0; k < 4; k++) begin
          e.d = 16'h0000; e.done = (k == 3);
          sb.push_back(e);
        end
      end
`else
      e.d = d; e.done = l;
      sb.push_back(e);
`endif
    end
    $display("write data=%04h last=%0d ready=%0d", d, l, WR_READY);
    @(negedge CLK);
    WR_VALID = 1'b0;
    WR_LAST  = 1'b0;
  endtask

  // Run with EN=1 until every expected sample has been seen (bounded)
  task automatic drain();
    EN = 1'b1;
    for (int k = 0; k < 80 && sb.size() != 0; k++) @(negedge CLK);
    @(negedge CLK);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_level", 32'(LEVEL), 32'd0);
    chk("drain_busy", 32'(BUSY), 32'd0);
  endtask

  // Monitor: inspects outputs 1 time unit after each rising edge
  logic        prev_r = 1'b0;
  logic [15:0] prev_d = '0;
  always @(posedge CLK) begin
    automatic logic en_s  = EN;
    automatic logic rst_s = RST;
    automatic exp_t e;
    #1;
    if (!rst_s) begin
      chk("rst_r_out", 32'(R_OUT), 32'd0);
      chk("rst_d_out", 32'(D_OUT), 32'd0);
      chk("rst_frame_done", 32'(FRAME_DONE), 32'd0);
    end else if (en_s) begin
      if (R_OUT) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %04h expected none", D_OUT);
        end else begin
          e = sb.pop_front();
          $display("out data=%04h done=%0d (exp %04h done=%0d)", D_OUT, FRAME_DONE, e.d, e.done);
          chk("out_data", 32'(D_OUT), 32'(e.d));
          chk("out_frame_done", 32'(FRAME_DONE), 32'(e.done));
        end
      end else begin
        chk("idle_frame_done", 32'(FRAME_DONE), 32'd0);
      end
    end else begin
      chk("hold_r_out", 32'(R_OUT), 32'(prev_r));
      chk("hold_d_out", 32'(D_OUT), 32'(prev_d));
      chk("hold_frame_done", 32'(FRAME_DONE), 32'd0);
    end
    prev_r = R_OUT;
    prev_d = D_OUT;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset then idle
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("t1_r_out", 32'(R_OUT), 32'd0);
      chk("t1_d_out", 32'(D_OUT), 32'd0);
      chk("t1_level", 32'(LEVEL), 32'd0);
      chk("t1_wr_ready", 32'(WR_READY), 32'd1);
      chk("t1_busy", 32'(BUSY), 32'd0);
    end

    // 2: basic stream, 2-cycle write-to-output latency
    EN = 1'b1;
    wr(16'h0001, 1'b0, 1'b1);
    chk("t2_lat_r0", 32'(R_OUT), 32'd0);
    wr(16'h0002, 1'b0, 1'b1);
    chk("t2_lat_r1", 32'(R_OUT), 32'd1);
    chk("t2_lat_d1", 32'(D_OUT), 32'h0001);
    wr(16'h0003, 1'b1, 1'b1);
    chk("t2_d2", 32'(D_OUT), 32'h0002);
    @(negedge CLK);
    chk("t2_d3", 32'(D_OUT), 32'h0003);
`ifdef FIR_SRC_FLUSH_EN
    chk("t2_done3", 32'(FRAME_DONE), 32'd0);
`else
    chk("t2_done3", 32'(FRAME_DONE), 32'd1);
`endif
    drain();

    // 3: fill with EN=0, ninth write refused, then drain counting down
    EN = 1'b0;
    for (int i = 0; i < 8; i++) wr(16'h0100 + 16'(i), (i == 7), 1'b1);
    chk("t3_level_full", 32'(LEVEL), 32'd8);
    chk("t3_busy", 32'(BUSY), 32'd1);
    wr(16'h01FF, 1'b0, 1'b0);
    chk("t3_level_after_refuse", 32'(LEVEL), 32'd8);
    EN = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      chk("t3_level_down", 32'(LEVEL), 32'(8 - k));
    end
    drain();

    // 4: EN toggling 1,0,1,0 with two queued samples
    EN = 1'b0;
    wr(16'hA5A5, 1'b0, 1'b1);
    wr(16'h5A5A, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      EN = (i % 2 == 0);
      @(negedge CLK);
    end
    drain();

`ifdef FIR_SRC_FLUSH_EN
    // 5: flush zeros between frames
    EN = 1'b1;
    wr(16'h0010, 1'b0, 1'b1);
    wr(16'h0020, 1'b1, 1'b1);
    wr(16'h0030, 1'b1, 1'b1);
    drain();
`endif

    // 6: reset with queued samples (FSM in FLUSH when the macro is defined)
    EN = 1'b0;
    wr(16'h0061, 1'b1, 1'b1);
    for (int i = 2; i <= 6; i++) wr(16'h0060 + 16'(i), 1'b0, 1'b1);
    EN = 1'b1;
    @(negedge CLK);
    EN = 1'b0;
    chk("t6_level_before", 32'(LEVEL), 32'd5);
    chk("t6_busy_before", 32'(BUSY), 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    sb.delete();
    chk("t6_level", 32'(LEVEL), 32'd0);
    chk("t6_r_out", 32'(R_OUT), 32'd0);
    chk("t6_d_out", 32'(D_OUT), 32'd0);
    chk("t6_busy", 32'(BUSY), 32'd0);
    chk("t6_wr_ready", 32'(WR_READY), 32'd1);
    EN = 1'b1;
    repeat (10) @(negedge CLK);
    chk("t6_still_empty", 32'(LEVEL), 32'd0);
    wr(16'h0077, 1'b1, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
